lane_shuffler: RTL and testbench

Parametrised, programmable lane-shuffling register. Holds a word of LANES lanes, each LANE_W bits wide, and applies one shuffle/insert operation per enabled step. Operations are read from a programmable sequence table of SEQ_DEPTH entries that a pointer walks through and wraps around. This is the generalised form of our fixed 2-lane, 4-phase scrambler: the reset-default table with LANES=2 reproduces that legacy behaviour exactly. It sits in the same datapath as a keyed byte/nibble mixer, between input byte sources and downstream checkers.

---
 rtl/lane_shuffler_pkg.sv | 43 ++++
 rtl/lane_shuffler_seq.sv | 54 +++++
 rtl/lane_shuffler.sv | 138 +++++++++++++
 tb/tb_lane_shuffler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_shuffler_pkg.sv
// lane_shuffler_pkg: opcodes, default sequence and fill helper
// shared by the lane shuffler datapath and its sequencer.
package lane_shuffler_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ROTH = 3'd1,
        OP_SHA  = 3'd2,
        OP_SHB  = 3'd3,
        OP_NREV = 3'd4,
        OP_XAB  = 3'd5,
        OP_FILL = 3'd6,
        OP_CLR  = 3'd7
    } op_e;

    localparam op_e DEFAULT_SEQ [4] = '{OP_ROTH, OP_SHA, OP_SHB, OP_NREV};

    localparam int MAX_LANE_W = 32;
    localparam int MAX_WORD_W = 256;
    localparam int LW_IW      = $clog2(MAX_LANE_W);
    localparam int WW_IW      = $clog2(MAX_WORD_W);

    // Fill pattern: odd lanes take a, even lanes take b.
    function automatic logic [MAX_WORD_W-1:0] fill_word(
        input int                    lanes,
        input int                    lane_w,
        input logic [MAX_LANE_W-1:0] a,
        input logic [MAX_LANE_W-1:0] b
    );
        logic [MAX_WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < MAX_WORD_W; i++) begin
            if (i < lanes * lane_w) begin
                if (((i / lane_w) % 2) == 1)
                    w[WW_IW'(i)] = a[LW_IW'(i % lane_w)];
                else
                    w[WW_IW'(i)] = b[LW_IW'(i % lane_w)];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/lane_shuffler_seq.sv
// lane_shuffler_seq: programmable opcode table with a wrapping
// pointer; presents the opcode for the current step.
module lane_shuffler_seq
    import lane_shuffler_pkg::*;
#(
    parameter  int SEQ_DEPTH = 4,
    localparam int AW        = $clog2(SEQ_DEPTH)
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          step_en,
    input  logic          restart,
    input  logic [AW-1:0] seq_last,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  op_e           prog_op,
    output logic [AW-1:0] ptr,
    output logic          wrap,
    output op_e           cur_op
);

    op_e tbl [SEQ_DEPTH];

    // Table: reload defaults on reset, else accept writes.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            for (int i = 0; i < SEQ_DEPTH; i++)
                tbl[i] <= DEFAULT_SEQ[i[1:0]];
        end else if (prog_we) begin
            tbl[prog_addr] <= prog_op;
        end
    end

    // Pointer walk; ">=" also catches seq_last lowered below ptr.
    always_ff @(posedge clk) begin
        if (!nReset || restart) begin
            ptr  <= '0;
            wrap <= 1'b0;
        end else if (step_en) begin
            if (ptr >= seq_last) begin
                ptr  <= '0;
                wrap <= 1'b1;
            end else begin
                ptr  <= ptr + AW'(1);
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    assign cur_op = tbl[ptr];

endmodule

// File: rtl/lane_shuffler.sv
// lane_shuffler: multi-lane shuffle register driven by a
// programmable opcode sequence.
module lane_shuffler
    import lane_shuffler_pkg::*;
#(
    parameter  int LANE_W    = 8,
    parameter  int LANES     = 2,
    parameter  int SEQ_DEPTH = 4,
    localparam int AW        = $clog2(SEQ_DEPTH),
    localparam int W         = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [LANE_W-1:0] a_in,
    input  logic [LANE_W-1:0] b_in,
    input  logic              step_en,
    input  logic              restart,
    input  logic [AW-1:0]     seq_last,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [2:0]        prog_op,
    output logic [W-1:0]      out,
    output logic [AW-1:0]     ptr,
    output logic              wrap
);

    localparam int H   = LANES / 2;
    localparam int NIB = W / 4;

    if (LANE_W % 4 != 0) begin : g_err_lane_w
        $error("LANE_W must be a multiple of 4");
    end
    if (LANES % 2 != 0 || LANES < 2) begin : g_err_lanes
        $error("LANES must be even and at least 2");
    end
    if (SEQ_DEPTH < 2 || (SEQ_DEPTH & (SEQ_DEPTH - 1)) != 0) begin : g_err_depth
        $error("SEQ_DEPTH must be a power of two, at least 2");
    end
    if (LANE_W >= MAX_LANE_W || W >= MAX_WORD_W) begin : g_err_size
        $error("word exceeds fill helper limits");
    end

    op_e cur_op;

    lane_shuffler_seq #(
        .SEQ_DEPTH(SEQ_DEPTH)
    ) u_seq (
        .clk      (clk),
        .nReset   (nReset),
        .step_en  (step_en),
        .restart  (restart),
        .seq_last (seq_last),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_op  (op_e'(prog_op)),
        .ptr      (ptr),
        .wrap     (wrap),
        .cur_op   (cur_op)
    );

    logic [MAX_LANE_W-1:0] a_ext;
    logic [MAX_LANE_W-1:0] b_ext;
    logic [MAX_WORD_W-1:0] fill_full;
    logic                  unused_fill;
    logic [W-1:0]          fill;

    // Zero-extend lane inputs for the width-generic fill helper.
    always_comb begin
        a_ext             = '0;
        b_ext             = '0;
        a_ext[LANE_W-1:0] = a_in;
        b_ext[LANE_W-1:0] = b_in;
        fill_full         = fill_word(LANES, LANE_W, a_ext, b_ext);
    end

    assign fill        = fill_full[W-1:0];
    assign unused_fill = ^fill_full[MAX_WORD_W-1:W];

    logic [W-1:0] rot_w;
    logic [W-1:0] sha_w;
    logic [W-1:0] shb_w;
    logic [W-1:0] nrev_w;
    logic [W-1:0] xab_w;
    logic [W-1:0] nxt;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign rot_w[i*LANE_W +: LANE_W] =
            out[((i + H) % LANES)*LANE_W +: LANE_W];
        if (i == 0) begin : g_sha0
            assign sha_w[i*LANE_W +: LANE_W] = a_in;
        end else begin : g_shan
            assign sha_w[i*LANE_W +: LANE_W] =
                out[(i-1)*LANE_W +: LANE_W];
        end
        if (i == LANES - 1) begin : g_shbn
            assign shb_w[i*LANE_W +: LANE_W] = b_in;
        end else begin : g_shb
            assign shb_w[i*LANE_W +: LANE_W] =
                out[(i+1)*LANE_W +: LANE_W];
        end
        if (i % 2 == 1) begin : g_xa
            assign xab_w[i*LANE_W +: LANE_W] =
                out[i*LANE_W +: LANE_W] ^ a_in;
        end else begin : g_xb
            assign xab_w[i*LANE_W +: LANE_W] =
                out[i*LANE_W +: LANE_W] ^ b_in;
        end
    end

    for (genvar k = 0; k < NIB; k++) begin : g_nib
        assign nrev_w[k*4 +: 4] = out[(NIB-1-k)*4 +: 4];
    end

    // Opcode mux selecting the next register value.
    always_comb begin
        nxt = out;
        case (cur_op)
            OP_NOP:  nxt = out;
            OP_ROTH: nxt = rot_w;
            OP_SHA:  nxt = sha_w;
            OP_SHB:  nxt = shb_w;
            OP_NREV: nxt = nrev_w;
            OP_XAB:  nxt = xab_w;
            OP_FILL: nxt = fill;
            OP_CLR:  nxt = '0;
            default: nxt = out;
        endcase
    end

    // Shuffle register: fill on reset/restart, else step.
    always_ff @(posedge clk) begin
        if (!nReset || restart)
            out <= fill;
        else if (step_en)
            out <= nxt;
    end

endmodule

// File: tb/tb_lane_shuffler.sv
// tb_lane_shuffler: directed and random checks of two
// lane_shuffler configurations against a lane-level model.
module tb_lane_shuffler;

    logic clk;
    logic nReset;

    logic [7:0]  a2, b2;
    logic        step2, rs2, we2;
    logic [1:0]  sl2, addr2;
    logic [2:0]  op2;
    logic [15:0] o2;
    logic [1:0]  p2;
    logic        w2;

    logic [7:0]  a4, b4;
    logic        step4, rs4, we4;
    logic [2:0]  sl4, addr4;
    logic [2:0]  op4;
    logic [31:0] o4;
    logic [2:0]  p4;
    logic        w4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_out  [2];
    int          m_ptr  [2];
    bit          m_wrap [2];
    int          m_tbl  [2][8];

    lane_shuffler #(.LANE_W(8), .LANES(2), .SEQ_DEPTH(4)) dut2 (
        .clk(clk), .nReset(nReset), .a_in(a2), .b_in(b2),
        .step_en(step2), .restart(rs2), .seq_last(sl2),
        .prog_we(we2), .prog_addr(addr2), .prog_op(op2),
        .out(o2), .ptr(p2), .wrap(w2)
    );

    lane_shuffler #(.LANE_W(8), .LANES(4), .SEQ_DEPTH(8)) dut4 (
        .clk(clk), .nReset(nReset), .a_in(a4), .b_in(b4),
        .step_en(step4), .restart(rs4), .seq_last(sl4),
        .prog_we(we4), .prog_addr(addr4), .prog_op(op4),
        .out(o4), .ptr(p4), .wrap(w4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fillw(input int n,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++)
            r[i*8 +: 8] = (i % 2 == 1) ? a : b;
        return r;
    endfunction

    function automatic logic [31:0] apply(input int op, input int n,
                                          input logic [31:0] w,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0]  ln [4];
        logic [7:0]  rn [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            ln[i] = w[i*8 +: 8];
            rn[i] = ln[i];
        end
        r = '0;
        case (op)
            1: for (int i = 0; i < n; i++) rn[i] = ln[(i + n/2) % n];
            2: for (int i = 0; i < n; i++) rn[i] = (i == 0) ? a : ln[i-1];
            3: for (int i = 0; i < n; i++) rn[i] = (i == n-1) ? b : ln[i+1];
            5: for (int i = 0; i < n; i++) rn[i] = ln[i] ^ ((i % 2 == 1) ? a : b);
            default: ;
        endcase
        for (int i = 0; i < n; i++) r[i*8 +: 8] = rn[i];
        if (op == 4) begin
            r = '0;
            for (int k = 0; k < 2*n; k++)
                r[k*4 +: 4] = w[(2*n-1-k)*4 +: 4];
        end
        if (op == 6) r = fillw(n, a, b);
        if (op == 7) r = '0;
        return r;
    endfunction

    task automatic model_upd(input int d, input logic [7:0] a,
                             input logic [7:0] b, input bit st,
                             input bit rs, input int sl, input bit we,
                             input int addr, input int op);
        int n;
        int depth;
        int old;
        int dflt [4];
        dflt  = '{1, 2, 3, 4};
        n     = (d == 0) ? 2 : 4;
        depth = (d == 0) ? 4 : 8;
        if (!nReset) begin
            m_out[d]  = fillw(n, a, b);
            m_ptr[d]  = 0;
            m_wrap[d] = 0;
            for (int i = 0; i < depth; i++) m_tbl[d][i] = dflt[i % 4];
            return;
        end
        old = m_tbl[d][m_ptr[d]];
        if (we) m_tbl[d][addr] = op;
        if (rs) begin
            m_out[d]  = fillw(n, a, b);
            m_ptr[d]  = 0;
            m_wrap[d] = 0;
        end else if (st) begin
            m_out[d] = apply(old, n, m_out[d], a, b);
            if (m_ptr[d] >= sl) begin
                m_ptr[d]  = 0;
                m_wrap[d] = 1;
            end else begin
                m_ptr[d]  = m_ptr[d] + 1;
                m_wrap[d] = 0;
            end
        end else begin
            m_wrap[d] = 0;
        end
    endtask

    task automatic tick();
        model_upd(0, a2, b2, step2, rs2, int'(sl2), we2,
                  int'(addr2), int'(op2));
        model_upd(1, a4, b4, step4, rs4, int'(sl4), we4,
                  int'(addr4), int'(op4));
        @(posedge clk);
        #1;
        chk("out2",  32'(o2), m_out[0]);
        chk("ptr2",  32'(p2), 32'(m_ptr[0]));
        chk("wrap2", 32'(w2), 32'(m_wrap[0]));
        chk("out4",  o4,      m_out[1]);
        chk("ptr4",  32'(p4), 32'(m_ptr[1]));
        chk("wrap4", 32'(w4), 32'(m_wrap[1]));
    endtask

    logic [15:0] legacy [5];

    initial begin
        legacy = '{16'h3412, 16'h12AB, 16'hCD12, 16'h21DC, 16'hDC21};
        nReset = 1'b0;
        a2 = 8'h12; b2 = 8'h34; step2 = 0; rs2 = 0; we2 = 0;
        sl2 = 2'd3; addr2 = 0; op2 = 0;
        a4 = 8'h11; b4 = 8'h22; step4 = 0; rs4 = 0; we4 = 0;
        sl4 = 3'd0; addr4 = 0; op4 = 0;
        tick();
        chk("rst_out2", 32'(o2), 32'h1234);
        chk("rst_out4", o4, 32'h11221122);
        nReset = 1'b1;

        a2 = 8'hAB; b2 = 8'hCD; step2 = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("legacy_out", 32'(o2), 32'(legacy[k]));
            chk("legacy_wrap", 32'(w2), (k == 3) ? 32'd1 : 32'd0);
        end
        step2 = 0;

        we4 = 1; addr4 = 0; op4 = 3'd2; a4 = 8'h5A;
        tick();
        we4 = 0; step4 = 1;
        tick();
        chk("l4_sha1", o4, 32'h2211225A);
        chk("l4_wrap1", 32'(w4), 32'd1);
        tick();
        chk("l4_sha2", o4, 32'h11225A5A);
        chk("l4_wrap2", 32'(w4), 32'd1);

        a4 = 8'h12; tick();
        a4 = 8'h34; tick();
        a4 = 8'h56; tick();
        a4 = 8'h78; tick();
        chk("l4_load", o4, 32'h12345678);
        step4 = 0; we4 = 1; op4 = 3'd4;
        tick();
        we4 = 0; step4 = 1;
        tick();
        chk("nrev", o4, 32'h87654321);
        step4 = 0; we4 = 1; op4 = 3'd5;
        tick();
        we4 = 0; step4 = 1; a4 = 8'hFF; b4 = 8'h00;
        tick();
        chk("xab", o4, 32'h7865BC21);
        step4 = 0;

        rs2 = 1; tick(); rs2 = 0;
        sl2 = 2'd3; step2 = 1;
        tick(); tick(); tick();
        chk("lower_ptr3", 32'(p2), 32'd3);
        sl2 = 2'd1;
        tick();
        chk("lower_ptr0", 32'(p2), 32'd0);
        chk("lower_wrap", 32'(w2), 32'd1);

        we2 = 1; addr2 = 0; op2 = 3'd7;
        tick();
        we2 = 0;
        tick();
        tick();
        chk("wr_new_op", 32'(o2), 32'd0);

        rs2 = 1; a2 = 8'h55; b2 = 8'h66;
        tick();
        chk("rs_step_out", 32'(o2), 32'h5566);
        chk("rs_step_ptr", 32'(p2), 32'd0);
        rs2 = 0; step2 = 0;

        we4 = 1; op4 = 3'd7;
        for (int i = 0; i < 8; i++) begin
            addr4 = 3'(i);
            tick();
        end
        we4 = 0; sl4 = 3'd7; step4 = 1;
        tick();
        chk("clr_out", o4, 32'd0);
        step4 = 0; nReset = 0; a4 = 8'h11; b4 = 8'h22;
        tick();
        chk("mrst_out", o4, 32'h11221122);
        chk("mrst_ptr", 32'(p4), 32'd0);
        nReset = 1; step4 = 1;
        tick();
        a4 = 8'h33;
        tick();
        chk("mrst_dflt", o4, 32'h22112233);
        step4 = 0;

        for (int k = 0; k < 400; k++) begin
            nReset = ($urandom_range(0, 63) != 0);
            a2 = 8'($urandom); b2 = 8'($urandom);
            a4 = 8'($urandom); b4 = 8'($urandom);
            step2 = ($urandom_range(0, 3) != 0);
            step4 = ($urandom_range(0, 3) != 0);
            rs2 = ($urandom_range(0, 15) == 0);
            rs4 = ($urandom_range(0, 15) == 0);
            we2 = ($urandom_range(0, 3) == 0);
            we4 = ($urandom_range(0, 3) == 0);
            addr2 = 2'($urandom); addr4 = 3'($urandom);
            op2 = 3'($urandom); op4 = 3'($urandom);
            if ($urandom_range(0, 7) == 0) sl2 = 2'($urandom);
            if ($urandom_range(0, 7) == 0) sl4 = 3'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
